// File: rtl/time_counter_hms.sv
// time_counter_hms: BCD hh:mm:ss timekeeper driven by a divider tick, with run/stop and validated load.
// Ports: clk_in/nrst (sync active-low reset), tick_in (one-cycle advance pulse), run (count enable),
//   load + ld_hh/ld_mm/ld_ss (BCD load request), hh/mm/ss (BCD time), sec_stb/min_stb/day_stb
//   (rollover strobes), load_err (rejected load). Optional macro ALARM_EN adds al_set/al_hh/al_mm and alarm.
module time_counter_hms #(
  parameter int TICKS_PER_SEC = 1,
  parameter int HOUR_MAX = 23
) (
  input  logic       clk_in,
  input  logic       nrst,
  input  logic       tick_in,
  input  logic       run,
  input  logic       load,
  input  logic [7:0] ld_hh,
  input  logic [7:0] ld_mm,
  input  logic [7:0] ld_ss,
`ifdef ALARM_EN
  input  logic       al_set,
  input  logic [7:0] al_hh,
  input  logic [7:0] al_mm,
  output logic       alarm,
`endif
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       sec_stb,
  output logic       min_stb,
  output logic       day_stb,
  output logic       load_err
);
  localparam int PW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [7:0] H_LAST = HOUR_MAX == 11 ? 8'h11 : 8'h23;
  // With both digits <= 9, packed BCD orders like its decimal value, so one compare bounds the field.
  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] lim);
    return v[3:0] <= 4'd9 && v[7:4] <= 4'd9 && v <= lim;
  endfunction
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0] hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic sec_q, sec_d, min_q, min_d, day_q, day_d, err_q, err_d;
  logic ld_ok, ld_go, cnt, adv, s_w, m_w, h_w;
  always_comb begin
    ld_ok = bcd_ok(ld_hh, H_LAST) && bcd_ok(ld_mm, 8'h59) && bcd_ok(ld_ss, 8'h59);
    ld_go = load && ld_ok;
    cnt = tick_in && run && !load;
    adv = cnt && presc_q == P_LAST;
    s_w = ss_q == 8'h59;
    m_w = mm_q == 8'h59;
    h_w = hh_q == H_LAST;
    presc_d = ld_go ? '0 : cnt ? (presc_q == P_LAST ? '0 : presc_q + PW'(1)) : presc_q;
    ss_d = ld_go ? ld_ss : adv ? (s_w ? 8'h00 : bcd_inc(ss_q)) : ss_q;
    mm_d = ld_go ? ld_mm : adv && s_w ? (m_w ? 8'h00 : bcd_inc(mm_q)) : mm_q;
    hh_d = ld_go ? ld_hh : adv && s_w && m_w ? (h_w ? 8'h00 : bcd_inc(hh_q)) : hh_q;
    sec_d = adv;
    min_d = adv && s_w;
    day_d = adv && s_w && m_w && h_w;
    err_d = load && !ld_ok;
  end
  always_ff @(posedge clk_in) begin
    if (!nrst) begin
      presc_q <= '0;
      hh_q <= 8'h00;
      mm_q <= 8'h00;
      ss_q <= 8'h00;
      sec_q <= 1'b0;
      min_q <= 1'b0;
      day_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      hh_q <= hh_d;
      mm_q <= mm_d;
      ss_q <= ss_d;
      sec_q <= sec_d;
      min_q <= min_d;
      day_q <= day_d;
      err_q <= err_d;
    end
  end
  assign hh = hh_q;
  assign mm = mm_q;
  assign ss = ss_q;
  assign sec_stb = sec_q;
  assign min_stb = min_q;
  assign day_stb = day_q;
  assign load_err = err_q;
`ifdef ALARM_EN
  logic [7:0] al_hh_q, al_mm_q;
  logic alarm_q, alarm_d;
  // Only a counting advance can fire; loads landing on the alarm time stay silent.
  always_comb alarm_d = adv && ss_d == 8'h00 && hh_d == al_hh_q && mm_d == al_mm_q;
  always_ff @(posedge clk_in) begin
    if (!nrst) begin
      al_hh_q <= 8'hFF;
      al_mm_q <= 8'hFF;
      alarm_q <= 1'b0;
    end else begin
      al_hh_q <= al_set ? al_hh : al_hh_q;
      al_mm_q <= al_set ? al_mm : al_mm_q;
      alarm_q <= alarm_d;
    end
  end
  assign alarm = alarm_q;
`endif
endmodule

// File: tb/tb_time_counter_hms.sv
// tb_time_counter_hms: table-driven and sequence checks of time_counter_hms in three parameter sets.
module tb_time_counter_hms;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic nrst, tick, run, load;
  logic [7:0] lh, lm, ls;
  logic [7:0] hh [3];
  logic [7:0] mm [3];
  logic [7:0] ss [3];
  logic sec [3];
  logic mn [3];
  logic day [3];
  logic err [3];
`ifdef ALARM_EN
  logic al_set;
  logic [7:0] al_hh, al_mm;
  logic alarm [3];
`endif
  // instance 0: 1 tick/s, 24h; instance 1: 4 ticks/s, 24h; instance 2: 1 tick/s, 12h
  for (genvar g = 0; g < 3; g++) begin : g_dut
    time_counter_hms #(.TICKS_PER_SEC(g == 1 ? 4 : 1), .HOUR_MAX(g == 2 ? 11 : 23)) u_dut (
      .clk_in(clk), .nrst(nrst), .tick_in(tick), .run(run), .load(load),
      .ld_hh(lh), .ld_mm(lm), .ld_ss(ls),
`ifdef ALARM_EN
      .al_set(al_set), .al_hh(al_hh), .al_mm(al_mm), .alarm(alarm[g]),
`endif
      .hh(hh[g]), .mm(mm[g]), .ss(ss[g]),
      .sec_stb(sec[g]), .min_stb(mn[g]), .day_stb(day[g]), .load_err(err[g])
    );
  end
  typedef struct {
    logic rn, tk, rr, ld;
    logic [7:0] h, m, s, eh, em, es;
    logic [3:0] est;
  } vec_t;
  typedef struct {
    logic [7:0] h, m, s;
    logic [3:0] st;
  } exp_t;
  vec_t vt[$];
  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic add(input logic rn, tk, rr, ld, input logic [7:0] h, m, s, eh, em, es, input logic [3:0] est);
    vec_t v;
    v = '{rn, tk, rr, ld, h, m, s, eh, em, es, est};
    vt.push_back(v);
  endtask
  task automatic drive(input logic rn, tk, rr, ld, input logic [7:0] h, m, s);
    nrst = rn;
    tick = tk;
    run = rr;
    load = ld;
    lh = h;
    lm = m;
    ls = s;
  endtask
  task automatic cyc(input logic rn, tk, rr, ld, input logic [7:0] h, m, s);
    drive(rn, tk, rr, ld, h, m, s);
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] bcd(input int i);
    return 8'((i / 10) * 16 + i % 10);
  endfunction
  initial begin
    exp_t e;
    int nsec;
`ifdef ALARM_EN
    al_set = 1'b0;
    al_hh = 8'h00;
    al_mm = 8'h00;
`endif
    drive(0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
    add(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
    add(0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
    add(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
    for (int i = 1; i <= 10; i++) add(1, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, bcd(i), 4'b1000);
    add(1, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 4'b0000);
    add(1, 0, 1, 1, 8'h23, 8'h59, 8'h58, 8'h23, 8'h59, 8'h58, 4'b0000);
    add(1, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h23, 8'h59, 8'h59, 4'b1000);
    add(1, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'b1110);
    add(1, 1, 1, 1, 8'h12, 8'h34, 8'h56, 8'h12, 8'h34, 8'h56, 4'b0000);
    add(1, 0, 1, 1, 8'h01, 8'h60, 8'h00, 8'h12, 8'h34, 8'h56, 4'b0001);
    add(1, 0, 1, 1, 8'h01, 8'h00, 8'h0A, 8'h12, 8'h34, 8'h56, 4'b0001);
    add(1, 0, 1, 1, 8'h24, 8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 4'b0001);
    add(1, 0, 1, 1, 8'h1A, 8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 4'b0001);
    add(1, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 4'b0000);
    add(1, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 4'b0000);
    add(1, 0, 0, 1, 8'h00, 8'h59, 8'h59, 8'h00, 8'h59, 8'h59, 4'b0000);
    add(1, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 4'b1100);
    add(1, 0, 1, 1, 8'h09, 8'h59, 8'h59, 8'h09, 8'h59, 8'h59, 4'b0000);
    add(1, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 4'b1100);
    add(1, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h01, 4'b1000);
    add(1, 1, 1, 1, 8'h00, 8'h60, 8'h00, 8'h10, 8'h00, 8'h01, 4'b0001);
    add(1, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h01, 4'b0000);
    add(1, 0, 1, 1, 8'h19, 8'h59, 8'h59, 8'h19, 8'h59, 8'h59, 4'b0000);
    add(1, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 4'b1100);
    add(0, 1, 1, 1, 8'h05, 8'h05, 8'h05, 8'h00, 8'h00, 8'h00, 4'b0000);
    foreach (vt[i]) begin
      drive(vt[i].rn, vt[i].tk, vt[i].rr, vt[i].ld, vt[i].h, vt[i].m, vt[i].s);
      sb.push_back('{vt[i].eh, vt[i].em, vt[i].es, vt[i].est});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("vec%0d_time", i), {hh[0], mm[0], ss[0]}, {e.h, e.m, e.s});
      chk($sformatf("vec%0d_stb", i), {sec[0], mn[0], day[0], err[0]}, e.st);
    end
    cyc(0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
    nsec = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(1, 1, 1, 0, 8'h00, 8'h00, 8'h00);
      nsec += int'(sec[1]);
      cyc(1, 0, 1, 0, 8'h00, 8'h00, 8'h00);
      nsec += int'(sec[1]);
    end
    chk("p4_7ticks_ss", ss[1], 8'h01);
    chk("p4_sec_count", nsec, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 0, 8'h00, 8'h00, 8'h00);
      cyc(1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    end
    chk("p4_stopped_ss", ss[1], 8'h01);
    cyc(1, 1, 1, 0, 8'h00, 8'h00, 8'h00);
    chk("p4_resume_ss", ss[1], 8'h02);
    chk("p4_resume_sec", sec[1], 1);
    cyc(1, 1, 1, 0, 8'h00, 8'h00, 8'h00);
    cyc(1, 1, 1, 0, 8'h00, 8'h00, 8'h00);
    cyc(1, 1, 1, 1, 8'h12, 8'h34, 8'h56);
    chk("p4_load_time", {hh[1], mm[1], ss[1]}, 24'h123456);
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 8'h00, 8'h00, 8'h00);
    chk("p4_presc_cleared", ss[1], 8'h56);
    cyc(1, 1, 1, 0, 8'h00, 8'h00, 8'h00);
    chk("p4_after4_ss", ss[1], 8'h57);
    cyc(1, 0, 1, 1, 8'h11, 8'h59, 8'h59);
    chk("h11_load", {hh[2], mm[2], ss[2], err[2]}, {24'h115959, 1'b0});
    cyc(1, 1, 1, 0, 8'h00, 8'h00, 8'h00);
    chk("h11_wrap_time", {hh[2], mm[2], ss[2]}, 24'h000000);
    chk("h11_wrap_stb", {sec[2], mn[2], day[2]}, 3'b111);
    cyc(1, 0, 1, 1, 8'h12, 8'h00, 8'h00);
    chk("h11_reject12", {hh[2], err[2]}, {8'h00, 1'b1});
    chk("h23_accept12", {hh[0], err[0]}, {8'h12, 1'b0});
`ifdef ALARM_EN
    cyc(0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
    chk("al_reset", alarm[0], 0);
    al_set = 1'b1;
    al_hh = 8'h00;
    al_mm = 8'h01;
    cyc(1, 0, 1, 1, 8'h00, 8'h00, 8'h58);
    al_set = 1'b0;
    cyc(1, 1, 1, 0, 8'h00, 8'h00, 8'h00);
    chk("al_early", alarm[0], 0);
    cyc(1, 1, 1, 0, 8'h00, 8'h00, 8'h00);
    chk("al_fire", {alarm[0], hh[0], mm[0], ss[0]}, {1'b1, 24'h000100});
    cyc(1, 0, 1, 0, 8'h00, 8'h00, 8'h00);
    chk("al_one_cycle", alarm[0], 0);
    cyc(1, 0, 1, 1, 8'h00, 8'h01, 8'h00);
    chk("al_load_silent", alarm[0], 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
